servo_dispense_ctrl: RTL

//  Dispense sequencer driving position_select of the downstream 0/180-deg servo PWM stage.

---
 rtl/servo_dispense_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/servo_dispense_ctrl.sv
// Dispense sequencer: runs N open/close gate cycles on the servo position select
// per accepted command, with level abort and a one-cycle completion pulse.
module servo_dispense_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OPEN_MS  = 600,
  parameter int CLOSE_MS = 800,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             position_select,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] items_done,
  output logic             aborted,
  output logic [1:0]       state_dbg
);

  localparam int          CYC_MS     = CLK_FREQ / 1000;
  localparam int          OPEN_CYC   = OPEN_MS * CYC_MS;
  localparam int          CLOSE_CYC  = CLOSE_MS * CYC_MS;
  localparam logic [31:0] OPEN_LAST  = 32'(OPEN_CYC - 1);
  localparam logic [31:0] CLOSE_LAST = 32'(CLOSE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_CLOSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      timer;
  logic [CNT_W-1:0] remaining;

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and never depends on cmd_valid.
  assign cmd_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign position_select = (state == S_OPEN);
  assign state_dbg       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      remaining  <= '0;
      items_done <= '0;
      aborted    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            items_done <= '0;
            aborted    <= 1'b0;
            timer      <= '0;
            remaining  <= cmd_count;
            state      <= (cmd_count == '0) ? S_DONE : S_OPEN;
          end
        end
        S_OPEN: begin
          // Abort wins over the last open cycle, so the interrupted item is never counted.
          if (abort) begin
            aborted   <= 1'b1;
            remaining <= ONE;
            timer     <= '0;
            state     <= S_CLOSE;
          end else if (timer == OPEN_LAST) begin
            items_done <= items_done + ONE;
            timer      <= '0;
            state      <= S_CLOSE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_CLOSE: begin
          if (abort) aborted <= 1'b1;
          if (timer == CLOSE_LAST) begin
            timer <= '0;
            if (abort || remaining == ONE) begin
              remaining <= '0;
              state     <= S_DONE;
            end else begin
              remaining <= remaining - ONE;
              state     <= S_OPEN;
            end
          end else begin
            timer <= timer + 32'd1;
            if (abort) remaining <= ONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
